clock_group_reset_sequencer: RTL and testbench

CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

---
 rtl/clock_group_pkg.sv | 30 +++
 rtl/seq_cycle_counter.sv | 27 ++
 rtl/clock_group_reset_sequencer.sv | 122 ++++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/clock_group_pkg.sv
// rtl/clock_group_pkg.sv - shared state enum and output encodings for the clock group reset sequencer
package clock_group_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_QUIESCE  = 3'd1,
        ST_GATE_OFF = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RELEASE  = 3'd4
    } seq_state_t;

    // Output encoding: {quiesce_req, member_clock_en, member_reset}
    localparam logic [2:0] OUT_RUN      = 3'b010;
    localparam logic [2:0] OUT_QUIESCE  = 3'b110;
    localparam logic [2:0] OUT_GATE_OFF = 3'b001;
    localparam logic [2:0] OUT_HOLD     = 3'b011;
    localparam logic [2:0] OUT_RELEASE  = 3'b000;

    function automatic logic [2:0] state_outputs(input seq_state_t s);
        case (s)
            ST_RUN:      return OUT_RUN;
            ST_QUIESCE:  return OUT_QUIESCE;
            ST_GATE_OFF: return OUT_GATE_OFF;
            ST_HOLD:     return OUT_HOLD;
            ST_RELEASE:  return OUT_RELEASE;
            default:     return OUT_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// rtl/seq_cycle_counter.sv - clearable saturating phase counter with terminal compare
module seq_cycle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             at_terminal
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count up while enabled, holding at the top value instead of wrapping
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// rtl/clock_group_reset_sequencer.sv - quiesce, gate, reset and release sequencing for a member clock domain
module clock_group_reset_sequencer
    import clock_group_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int SETTLE_CYCLES   = 4,
    parameter int QUIESCE_TIMEOUT = 255,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_reset_req,
    input  logic quiesce_ack,
    output logic quiesce_req,
    output logic member_clock_en,
    output logic member_reset,
    output logic busy,
    output logic done,
    output logic timeout
);

    // A phase of N cycles ends on the cycle the counter shows N-1
    localparam logic [CNT_W-1:0] TERM_HOLD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_QUIESCE = CNT_W'(QUIESCE_TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic             pending;
    logic             timeout_hit;
    logic             state_change;
    logic [CNT_W-1:0] terminal;
    logic [CNT_W-1:0] count;
    logic             at_terminal;

    assign state_change = (next_state != state);

    seq_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (state_change),
        .enable      (state != ST_RUN),
        .terminal    (terminal),
        .count       (count),
        .at_terminal (at_terminal)
    );

    // Next-state selection; ack takes priority over quiesce expiry
    always_comb begin
        next_state  = state;
        terminal    = '0;
        timeout_hit = 1'b0;
        case (state)
            ST_RUN: begin
                if (sw_reset_req || pending) begin
                    next_state = ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                terminal = TERM_QUIESCE;
                if (quiesce_ack) begin
                    next_state = ST_GATE_OFF;
                end else if (at_terminal) begin
                    next_state  = ST_GATE_OFF;
                    timeout_hit = 1'b1;
                end
            end
            ST_GATE_OFF: begin
                terminal = TERM_SETTLE;
                if (at_terminal) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                terminal = TERM_HOLD;
                if (at_terminal) begin
                    next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                terminal = TERM_SETTLE;
                if (at_terminal) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_HOLD;
            end
        endcase
    end

    // State register and registered outputs decoded from the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state                                        <= ST_HOLD;
            {quiesce_req, member_clock_en, member_reset} <= OUT_HOLD;
            busy                                         <= 1'b1;
            done                                         <= 1'b0;
            timeout                                      <= 1'b0;
        end else begin
            state                                        <= next_state;
            {quiesce_req, member_clock_en, member_reset} <= state_outputs(next_state);
            busy                                         <= (next_state != ST_RUN);
            done                                         <= (state == ST_RELEASE) && (next_state == ST_RUN);
            timeout                                      <= timeout_hit;
        end
    end

    // One deferred request is remembered while busy; RUN consumes it
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (state == ST_RUN) begin
            pending <= 1'b0;
        end else if (sw_reset_req) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// tb/tb_clock_group_reset_sequencer.sv - directed self-checking bench for clock_group_reset_sequencer
module tb_clock_group_reset_sequencer;

    logic clock;
    logic reset;
    logic sw_reset_req;
    logic quiesce_ack;
    logic quiesce_req;
    logic member_clock_en;
    logic member_reset;
    logic busy;
    logic done;
    logic timeout;

    int tests_run;
    int tests_failed;

    int nq, ng, nh, nr, nt, nd, ok;
    int busy_seen;

    clock_group_reset_sequencer #(
        .HOLD_CYCLES     (16),
        .SETTLE_CYCLES   (4),
        .QUIESCE_TIMEOUT (8),
        .CNT_W           (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .sw_reset_req    (sw_reset_req),
        .quiesce_ack     (quiesce_ack),
        .quiesce_req     (quiesce_req),
        .member_clock_en (member_clock_en),
        .member_reset    (member_reset),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_quiesce_req"}, int'(quiesce_req), 0);
        check({tag, "_clock_en"}, int'(member_clock_en), 1);
        check({tag, "_member_reset"}, int'(member_reset), 1);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    // Walks one sequence until done, counting cycles spent in each phase.
    task automatic run_seq(input bit do_req, input int ack_at, input int hold_reqs,
                           output int q, output int g, output int h, output int r,
                           output int t, output int d, output int fin);
        q = 0; g = 0; h = 0; r = 0; t = 0; d = 0; fin = 0;
        if (do_req) begin
            sw_reset_req = 1'b1;
            tick();
            sw_reset_req = 1'b0;
        end
        for (int c = 0; c < 300; c++) begin
            if (timeout) t++;
            if (done) begin
                d++;
                fin = 1;
                break;
            end
            if (quiesce_req) begin
                q++;
                quiesce_ack = (ack_at >= 0) && (q - 1 == ack_at);
            end else begin
                quiesce_ack = 1'b0;
            end
            if (!member_clock_en && member_reset) g++;
            if (member_clock_en && member_reset) begin
                h++;
                sw_reset_req = (h <= hold_reqs);
            end else begin
                sw_reset_req = 1'b0;
            end
            if (!member_clock_en && !member_reset) r++;
            tick();
        end
        quiesce_ack  = 1'b0;
        sw_reset_req = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        sw_reset_req = 1'b0;
        quiesce_ack  = 1'b0;

        // Power-on: reset for three cycles, then HOLD 16, RELEASE 4, RUN with done
        tick(); tick(); tick();
        check_reset_values("por");
        reset = 1'b0;
        run_seq(1'b0, -1, 0, nq, ng, nh, nr, nt, nd, ok);
        check("por_finished", ok, 1);
        check("por_hold_cycles", nh, 16);
        check("por_release_cycles", nr, 4);
        check("por_quiesce_cycles", nq, 0);
        check("por_run_busy", int'(busy), 0);
        check("por_run_outputs", int'({quiesce_req, member_clock_en, member_reset}), 3'b010);
        tick();
        check("por_done_single", int'(done), 0);

        // Normal request, ack on the sixth QUIESCE cycle
        tick();
        run_seq(1'b1, 5, 0, nq, ng, nh, nr, nt, nd, ok);
        check("norm_finished", ok, 1);
        check("norm_quiesce_cycles", nq, 6);
        check("norm_gate_off_cycles", ng, 4);
        check("norm_hold_cycles", nh, 16);
        check("norm_release_cycles", nr, 4);
        check("norm_timeouts", nt, 0);
        tick();
        check("norm_done_single", int'(done), 0);

        // Ack never arrives: eight QUIESCE cycles then one timeout pulse
        run_seq(1'b1, -1, 0, nq, ng, nh, nr, nt, nd, ok);
        check("tmo_finished", ok, 1);
        check("tmo_quiesce_cycles", nq, 8);
        check("tmo_pulses", nt, 1);
        check("tmo_gate_off_cycles", ng, 4);
        tick();

        // Ack on the expiry cycle wins, no timeout pulse
        run_seq(1'b1, 7, 0, nq, ng, nh, nr, nt, nd, ok);
        check("ackexp_finished", ok, 1);
        check("ackexp_quiesce_cycles", nq, 8);
        check("ackexp_pulses", nt, 0);
        tick();

        // Three requests during HOLD collapse to one extra sequence
        run_seq(1'b1, 2, 3, nq, ng, nh, nr, nt, nd, ok);
        check("pend_first_finished", ok, 1);
        check("pend_first_run_busy", int'(busy), 0);
        tick();
        check("pend_requeue_quiesce", int'(quiesce_req), 1);
        check("pend_requeue_busy", int'(busy), 1);
        run_seq(1'b0, 1, 0, nq, ng, nh, nr, nt, nd, ok);
        check("pend_second_finished", ok, 1);
        check("pend_second_quiesce_cycles", nq, 2);
        check("pend_second_hold_cycles", nh, 16);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || done) busy_seen++;
        end
        check("pend_no_third_sequence", busy_seen, 0);

        // Reset during GATE_OFF with a request pending
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        quiesce_ack  = 1'b1;
        tick();
        quiesce_ack  = 1'b0;
        check("mid_in_gate_off", int'({quiesce_req, member_clock_en, member_reset}), 3'b001);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        reset        = 1'b1;
        tick();
        check_reset_values("mid");
        reset = 1'b0;
        run_seq(1'b0, -1, 0, nq, ng, nh, nr, nt, nd, ok);
        check("mid_finished", ok, 1);
        check("mid_hold_cycles", nh, 16);
        check("mid_release_cycles", nr, 4);
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("mid_pending_cleared", busy_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
